// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port controller.
// Requester indices, FSM states and register-file geometry.
package rf_pkg;

    localparam int REQ_CORE = 0;
    localparam int REQ_LLU  = 1;
    localparam int REQ_DBG  = 2;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per register marking a pending long-latency write.
// A reserve beats a same-cycle release; a flush wipes every bit.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_en_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam logic [NUM_REGS-1:0] BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    // Register 0 is hardwired, so it can never be reserved.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i && set_addr_i != '0) set_mask = BIT0 << set_addr_i;
        if (clr_en_i) clr_mask = BIT0 << clr_addr_i;
        busy_d = (busy_q & ~clr_mask) | set_mask;
        if (flush_i) busy_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port controller: arbitrates three writeback sources with
// starvation promotion, tracks long-latency reservations, and runs a full clear.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [ADDR_W-1:0]   req_addr0,
    input  logic [ADDR_W-1:0]   req_addr1,
    input  logic [ADDR_W-1:0]   req_addr2,
    input  logic [DATA_W-1:0]   req_data0,
    input  logic [DATA_W-1:0]   req_data1,
    input  logic [DATA_W-1:0]   req_data2,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] busy_mask,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                wEn,
    output logic [ADDR_W-1:0]   addrD,
    output logic [DATA_W-1:0]   dataD
);

    localparam int              CW       = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       starve1_q, starve1_d, starve2_q, starve2_d;
    logic                wen_q, wen_d, done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                arb_en, promo1, promo2;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;

    assign arb_en = (state_q == ARB) && !clr_start && !reset;
    assign promo1 = req_valid[REQ_LLU] && (starve1_q == CNT_MAX);
    assign promo2 = req_valid[REQ_DBG] && (starve2_q == CNT_MAX);

    // Promoted requesters pre-empt the fixed 0 > 1 > 2 order.
    always_comb begin
        req_ready = '0;
        if (arb_en) begin
            if (promo1)                  req_ready[REQ_LLU]  = 1'b1;
            else if (promo2)             req_ready[REQ_DBG]  = 1'b1;
            else if (req_valid[REQ_CORE]) req_ready[REQ_CORE] = 1'b1;
            else if (req_valid[REQ_LLU]) req_ready[REQ_LLU]  = 1'b1;
            else if (req_valid[REQ_DBG]) req_ready[REQ_DBG]  = 1'b1;
        end
        gnt_addr = req_addr0;
        gnt_data = req_data0;
        if (req_ready[REQ_LLU]) begin
            gnt_addr = req_addr1;
            gnt_data = req_data1;
        end else if (req_ready[REQ_DBG]) begin
            gnt_addr = req_addr2;
            gnt_data = req_data2;
        end
    end

    // During CLEAR the write address register doubles as the sweep counter.
    always_comb begin
        state_d   = state_q;
        starve1_d = starve1_q;
        starve2_d = starve2_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        case (state_q)
            ARB: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    starve1_d = '0;
                    starve2_d = '0;
                    wen_d     = 1'b1;
                    addr_d    = ADDR_W'(1);
                    data_d    = '0;
                end else begin
                    if (!req_valid[REQ_LLU] || req_ready[REQ_LLU]) starve1_d = '0;
                    else if (starve1_q != CNT_MAX) starve1_d = starve1_q + 1'b1;
                    if (!req_valid[REQ_DBG] || req_ready[REQ_DBG]) starve2_d = '0;
                    else if (starve2_q != CNT_MAX) starve2_d = starve2_q + 1'b1;
                    if (|req_ready) begin
                        wen_d  = (gnt_addr != '0);
                        addr_d = gnt_addr;
                        data_d = gnt_data;
                    end
                end
            end
            CLEAR: begin
                starve1_d = '0;
                starve2_d = '0;
                if (addr_q == LAST_REG) begin
                    state_d = ARB;
                    done_d  = 1'b1;
                end else begin
                    wen_d  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    data_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            starve1_q <= '0;
            starve2_q <= '0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve1_q <= starve1_d;
            starve2_q <= starve2_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (rsv_valid && (state_q == ARB)),
        .set_addr_i (rsv_addr),
        .clr_en_i   (req_valid[REQ_LLU] && req_ready[REQ_LLU]),
        .clr_addr_i (req_addr1),
        .flush_i    ((state_q == ARB) && clr_start),
        .busy_o     (busy_mask)
    );

    assign wEn      = wen_q;
    assign addrD    = addr_q;
    assign dataD    = data_q;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: priority, starvation, x0 writes,
// scoreboard set/clear, the clear sweep and reset during a sweep.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid, req_ready;
    logic [4:0]  req_addr0, req_addr1, req_addr2, rsv_addr, addrD;
    logic [31:0] req_data0, req_data1, req_data2, dataD, busy_mask;
    logic        rsv_valid, clr_start, clr_busy, clr_done, wEn;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_addr2 (req_addr2),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy_mask (busy_mask),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .wEn       (wEn),
        .addrD     (addrD),
        .dataD     (dataD)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
        req_data0 = '0; req_data1 = '0; req_data2 = '0;
        rsv_valid = 1'b0; rsv_addr = '0; clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wEn, addrD, dataD, busy_mask} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_regs got wEn=%b addrD=%0d dataD=%h busy=%h want all 0", wEn, addrD, dataD, busy_mask);
        end
        checks++;
        if ({clr_busy, clr_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_clr got busy=%b done=%b want 0 0", clr_busy, clr_done);
        end
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b want 000", req_ready);
        end
        req_valid = '0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_priority();
        req_valid = 3'b111;
        req_addr0 = 5'd3;  req_data0 = 32'hAAAA_0003;
        req_addr1 = 5'd4;  req_data1 = 32'hBBBB_0004;
        req_addr2 = 5'd6;  req_data2 = 32'hCCCC_0006;
        #3;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL prio_ready got %b want 001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({wEn, addrD, dataD} !== {1'b1, 5'd3, 32'hAAAA_0003}) begin
            errors++;
            $display("FAIL prio_write got wEn=%b addrD=%0d dataD=%h want 1 3 aaaa0003", wEn, addrD, dataD);
        end
        step();
        checks++;
        if (wEn !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle got wEn=%b want 0", wEn);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            req_addr0 = 5'(i + 1);
            req_data0 = 32'h100 + 32'(i);
            #3;
            checks++;
            if (req_ready !== 3'b001) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got %b want 001", i, req_ready);
            end
            step();
            checks++;
            if ({wEn, addrD, dataD} !== {1'b1, 5'(i + 1), 32'h100 + 32'(i)}) begin
                errors++;
                $display("FAIL b2b_write[%0d] got wEn=%b addrD=%0d dataD=%h want 1 %0d %h", i, wEn, addrD, dataD, i + 1, 32'h100 + 32'(i));
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_starvation();
        req_valid = 3'b101;
        req_addr0 = 5'd7; req_data0 = 32'h0000_0707;
        req_addr2 = 5'd9; req_data2 = 32'h0000_0909;
        for (int i = 0; i < 5; i++) begin
            #3;
            checks++;
            if (req_ready !== ((i < 4) ? 3'b001 : 3'b100)) begin
                errors++;
                $display("FAIL starve_ready[%0d] got %b want %b", i, req_ready, (i < 4) ? 3'b001 : 3'b100);
            end
            step();
        end
        checks++;
        if ({wEn, addrD, dataD} !== {1'b1, 5'd9, 32'h0000_0909}) begin
            errors++;
            $display("FAIL starve_write got wEn=%b addrD=%0d dataD=%h want 1 9 00000909", wEn, addrD, dataD);
        end
        #3;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL starve_reset got %b want 001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_x0_write();
        req_valid = 3'b001;
        req_addr0 = 5'd0; req_data0 = 32'hDEAD_BEEF;
        #3;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL x0_ready got %b want 001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (wEn !== 1'b0) begin
            errors++;
            $display("FAIL x0_wen got %b want 0", wEn);
        end
        step();
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        step();
        rsv_valid = 1'b0;
        checks++;
        if (busy_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL sb_set got %h want 00000020", busy_mask);
        end
        req_valid = 3'b010; req_addr1 = 5'd5; req_data1 = 32'h5555_0005;
        #3;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL sb_ready got %b want 010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({busy_mask, wEn, addrD} !== {32'h0, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL sb_clear got busy=%h wEn=%b addrD=%0d want 0 1 5", busy_mask, wEn, addrD);
        end
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        step();
        req_valid = 3'b010;
        step();
        req_valid = '0; rsv_addr = 5'd0;
        checks++;
        if (busy_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL sb_set_wins got %h want 00000020", busy_mask);
        end
        step();
        rsv_valid = 1'b0;
        checks++;
        if (busy_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL sb_x0_ignored got %h want 00000020", busy_mask);
        end
        req_valid = 3'b010;
        step();
        req_valid = '0;
        for (int r = 8; r < 12; r++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(r);
            step();
        end
        rsv_valid = 1'b0;
        checks++;
        if (busy_mask !== 32'h0000_0F00) begin
            errors++;
            $display("FAIL sb_prep got %h want 00000f00", busy_mask);
        end
    endtask

    task automatic test_clear();
        req_valid = 3'b111;
        req_addr0 = 5'd2; req_addr1 = 5'd8; req_addr2 = 5'd4;
        clr_start = 1'b1;
        #3;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL clr_start_ready got %b want 000", req_ready);
        end
        step();
        clr_start = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        for (int k = 1; k <= 31; k++) begin
            checks++;
            if ({req_ready, clr_busy, clr_done, wEn, addrD, dataD, busy_mask} !==
                {3'b000, 1'b1, 1'b0, 1'b1, 5'(k), 32'h0, 32'h0}) begin
                errors++;
                $display("FAIL clr_cycle[%0d] got ready=%b busy=%b done=%b wEn=%b addrD=%0d dataD=%h mask=%h want 000 1 0 1 %0d 0 0",
                         k, req_ready, clr_busy, clr_done, wEn, addrD, dataD, busy_mask, k);
            end
            step();
            rsv_valid = 1'b0;
        end
        checks++;
        if ({clr_done, clr_busy, wEn, busy_mask} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL clr_done got done=%b busy=%b wEn=%b mask=%h want 1 0 0 0", clr_done, clr_busy, wEn, busy_mask);
        end
        #3;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL clr_resume got %b want 001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({clr_done, wEn, addrD} !== {1'b0, 1'b1, 5'd2}) begin
            errors++;
            $display("FAIL clr_after got done=%b wEn=%b addrD=%0d want 0 1 2", clr_done, wEn, addrD);
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (9) step();
        checks++;
        if ({clr_busy, addrD} !== {1'b1, 5'd10}) begin
            errors++;
            $display("FAIL midclr_pos got busy=%b addrD=%0d want 1 10", clr_busy, addrD);
        end
        req_valid = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, wEn, addrD, dataD, busy_mask, clr_busy, clr_done} !==
            {3'b000, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midclr_reset got ready=%b wEn=%b addrD=%0d dataD=%h mask=%h busy=%b done=%b want all 0",
                     req_ready, wEn, addrD, dataD, busy_mask, clr_busy, clr_done);
        end
        step();
        reset = 1'b0;
        req_valid = 3'b001; req_addr0 = 5'd2; req_data0 = 32'h2222_0002;
        #2;
        checks++;
        if ({req_ready, clr_busy} !== {3'b001, 1'b0}) begin
            errors++;
            $display("FAIL midclr_arb got ready=%b busy=%b want 001 0", req_ready, clr_busy);
        end
        step();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({clr_done, clr_busy} !== 2'b00) begin
                errors++;
                $display("FAIL midclr_nodone[%0d] got done=%b busy=%b want 0 0", i, clr_done, clr_busy);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_back_to_back();
        test_starvation();
        test_x0_write();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
